// File: rtl/bcd_entry.sv
// bcd_entry: keypad digit entry into a sign + 2-digit BCD word,
// presented downstream with a valid/ready handshake.
module bcd_entry (
    input  logic       clk,
    input  logic       reset,
    input  logic       keyPressed,
    input  logic [3:0] keyCode,
    input  logic       outReady,
    output logic [8:0] bcdOut,
    output logic       outValid,
    output logic [8:0] liveBcd,
    output logic [1:0] digitCount,
    output logic       errPulse
);
    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL, DONE} state_t;
    state_t     state_q;
    logic       prev_key_q, sign_q, valid_q, err_q;
    logic [3:0] tens_q, ones_q;
    logic [1:0] count_q;
    logic [8:0] bcd_q;
    logic       key_ev, entry_zero;
    assign key_ev     = keyPressed & ~prev_key_q;
    assign entry_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EMPTY;
            prev_key_q <= 1'b1;
            sign_q     <= 1'b0;
            tens_q     <= 4'd0;
            ones_q     <= 4'd0;
            count_q    <= 2'd0;
            bcd_q      <= 9'd0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            prev_key_q <= keyPressed;
            err_q      <= 1'b0;
            // Transfer and clear share one path; other keys at the transfer edge are dropped.
            if ((valid_q && outReady) || (key_ev && keyCode == 4'd12)) begin
                state_q <= EMPTY;
                sign_q  <= 1'b0;
                tens_q  <= 4'd0;
                ones_q  <= 4'd0;
                count_q <= 2'd0;
                valid_q <= 1'b0;
            end else if (key_ev && state_q != DONE) begin
                if (keyCode < 4'd10) begin
                    case (state_q)
                        EMPTY: begin
                            ones_q  <= keyCode;
                            count_q <= 2'd1;
                            state_q <= PARTIAL;
                        end
                        PARTIAL: begin
                            tens_q  <= ones_q;
                            ones_q  <= keyCode;
                            count_q <= 2'd2;
                            state_q <= FULL;
                        end
                        default: err_q <= 1'b1;
                    endcase
                end else if (keyCode == 4'd10) begin
                    sign_q <= ~sign_q;
                end else if (keyCode == 4'd11) begin
                    if (state_q == FULL) begin
                        ones_q  <= tens_q;
                        tens_q  <= 4'd0;
                        count_q <= 2'd1;
                        state_q <= PARTIAL;
                    end else if (state_q == PARTIAL) begin
                        ones_q  <= 4'd0;
                        count_q <= 2'd0;
                        state_q <= EMPTY;
                    end
                end else if (keyCode == 4'd13) begin
                    if (state_q == EMPTY) begin
                        err_q <= 1'b1;
                    end else begin
                        bcd_q   <= {sign_q & ~entry_zero, tens_q, ones_q};
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
            end
        end
    end
    assign bcdOut     = bcd_q;
    assign outValid   = valid_q;
    assign liveBcd    = {sign_q, tens_q, ones_q};
    assign digitCount = count_q;
    assign errPulse   = err_q;
endmodule

// File: tb/tb_bcd_entry.sv
// tb_bcd_entry: table vectors, directed corner sequences and random stimulus
// checked against a digit-queue reference model of the entry stage.
module tb_bcd_entry;
    logic       clk = 1'b0, reset = 1'b0, keyPressed = 1'b0, outReady = 1'b0;
    logic [3:0] keyCode = 4'd0;
    logic [8:0] bcdOut, liveBcd;
    logic       outValid, errPulse;
    logic [1:0] digitCount;
    int checks = 0, errors = 0;

    bcd_entry dut (
        .clk(clk), .reset(reset), .keyPressed(keyPressed), .keyCode(keyCode),
        .outReady(outReady), .bcdOut(bcdOut), .outValid(outValid),
        .liveBcd(liveBcd), .digitCount(digitCount), .errPulse(errPulse)
    );

    always #5 clk = ~clk;

    bit         m_prev, m_sign, m_done, m_valid, m_err;
    int         m_dig[$];
    logic [8:0] m_bcd;

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%03h expected 0x%03h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] m_live();
        int t, o;
        t = (m_dig.size() == 2) ? m_dig[0] : 0;
        o = (m_dig.size() == 0) ? 0 : m_dig[m_dig.size()-1];
        return {m_sign, 4'(t), 4'(o)};
    endfunction

    task automatic model_reset();
        m_prev = 1; m_sign = 0; m_done = 0; m_valid = 0; m_err = 0; m_bcd = 0;
        m_dig.delete();
    endtask

    task automatic model_step(input bit kp, input logic [3:0] code, input bit rdy);
        bit ev;
        int n;
        ev = kp && !m_prev;
        m_prev = kp;
        m_err = 0;
        if ((m_valid && rdy) || (ev && code == 12)) begin
            m_dig.delete(); m_sign = 0; m_done = 0; m_valid = 0;
        end else if (ev && !m_done) begin
            if (code <= 9) begin
                if (m_dig.size() < 2) m_dig.push_back(int'(code)); else m_err = 1;
            end else if (code == 10) m_sign = !m_sign;
            else if (code == 11) begin
                if (m_dig.size() > 0) void'(m_dig.pop_back());
            end else if (code == 13) begin
                if (m_dig.size() == 0) m_err = 1;
                else begin
                    n = 0;
                    foreach (m_dig[i]) n = n * 10 + m_dig[i];
                    m_bcd = {m_sign && n != 0, 4'(n / 10), 4'(n % 10)};
                    m_valid = 1; m_done = 1;
                end
            end
        end
    endtask

    task automatic cmp_model();
        chk("live", liveBcd, m_live());
        chk("bcd", bcdOut, m_bcd);
        chk("valid", 9'(outValid), 9'(m_valid));
        chk("count", 9'(digitCount), 9'(m_dig.size()));
        chk("err", 9'(errPulse), 9'(m_err));
    endtask

    task automatic step(input bit kp, input logic [3:0] code, input bit rdy);
        keyPressed = kp; keyCode = code; outReady = rdy;
        model_step(kp, code, rdy);
        @(posedge clk); #1;
        cmp_model();
    endtask

    task automatic do_reset(input bit kp);
        reset = 1; keyPressed = kp; outReady = 0;
        @(posedge clk); #1;
        model_reset();
        reset = 0;
        cmp_model();
    endtask

    typedef struct {
        bit kp; logic [3:0] code; bit rdy;
        logic [8:0] live; logic [1:0] cnt; bit v; bit e; logic [8:0] bcd;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(bit kp, int code, bit rdy, int live, int cnt, bit v, bit e, int bcd);
        return '{kp, 4'(code), rdy, 9'(live), 2'(cnt), v, e, 9'(bcd)};
    endfunction

    initial begin
        logic [3:0] rc;
        do_reset(0);
        chk("rst_live", liveBcd, 9'h000);
        chk("rst_bcd", bcdOut, 9'h000);
        chk("rst_valid", 9'(outValid), 9'h0);
        chk("rst_count", 9'(digitCount), 9'h0);

        tbl.push_back(mk(0, 0, 0, 'h000, 0, 0, 0, 'h000));
        tbl.push_back(mk(1, 4, 0, 'h004, 1, 0, 0, 'h000));
        tbl.push_back(mk(0, 4, 0, 'h004, 1, 0, 0, 'h000));
        tbl.push_back(mk(1, 2, 0, 'h042, 2, 0, 0, 'h000));
        tbl.push_back(mk(0, 2, 0, 'h042, 2, 0, 0, 'h000));
        tbl.push_back(mk(1, 13, 0, 'h042, 2, 1, 0, 'h042));
        tbl.push_back(mk(0, 13, 0, 'h042, 2, 1, 0, 'h042));
        tbl.push_back(mk(0, 0, 1, 'h000, 0, 0, 0, 'h042));
        tbl.push_back(mk(1, 7, 1, 'h007, 1, 0, 0, 'h042));
        tbl.push_back(mk(0, 7, 0, 'h007, 1, 0, 0, 'h042));
        tbl.push_back(mk(1, 10, 0, 'h107, 1, 0, 0, 'h042));
        tbl.push_back(mk(0, 10, 0, 'h107, 1, 0, 0, 'h042));
        tbl.push_back(mk(1, 3, 0, 'h173, 2, 0, 0, 'h042));
        tbl.push_back(mk(0, 3, 0, 'h173, 2, 0, 0, 'h042));
        tbl.push_back(mk(1, 13, 1, 'h173, 2, 1, 0, 'h173));
        tbl.push_back(mk(0, 0, 1, 'h000, 0, 0, 0, 'h173));
        tbl.push_back(mk(1, 9, 0, 'h009, 1, 0, 0, 'h173));
        tbl.push_back(mk(0, 9, 0, 'h009, 1, 0, 0, 'h173));
        tbl.push_back(mk(1, 8, 0, 'h098, 2, 0, 0, 'h173));
        tbl.push_back(mk(0, 8, 0, 'h098, 2, 0, 0, 'h173));
        tbl.push_back(mk(1, 5, 0, 'h098, 2, 0, 1, 'h173));
        tbl.push_back(mk(0, 5, 0, 'h098, 2, 0, 0, 'h173));
        tbl.push_back(mk(1, 11, 0, 'h009, 1, 0, 0, 'h173));
        tbl.push_back(mk(0, 11, 0, 'h009, 1, 0, 0, 'h173));
        tbl.push_back(mk(1, 11, 0, 'h000, 0, 0, 0, 'h173));
        tbl.push_back(mk(0, 11, 0, 'h000, 0, 0, 0, 'h173));
        tbl.push_back(mk(1, 11, 0, 'h000, 0, 0, 0, 'h173));
        tbl.push_back(mk(0, 11, 0, 'h000, 0, 0, 0, 'h173));
        tbl.push_back(mk(1, 10, 0, 'h100, 0, 0, 0, 'h173));
        tbl.push_back(mk(0, 10, 0, 'h100, 0, 0, 0, 'h173));
        tbl.push_back(mk(1, 0, 0, 'h100, 1, 0, 0, 'h173));
        tbl.push_back(mk(0, 0, 0, 'h100, 1, 0, 0, 'h173));
        tbl.push_back(mk(1, 13, 0, 'h100, 1, 1, 0, 'h000));
        tbl.push_back(mk(0, 0, 1, 'h000, 0, 0, 0, 'h000));
        tbl.push_back(mk(1, 13, 0, 'h000, 0, 0, 1, 'h000));
        tbl.push_back(mk(0, 13, 0, 'h000, 0, 0, 0, 'h000));
        tbl.push_back(mk(1, 14, 0, 'h000, 0, 0, 0, 'h000));
        tbl.push_back(mk(0, 14, 0, 'h000, 0, 0, 0, 'h000));
        foreach (tbl[i]) begin
            step(tbl[i].kp, tbl[i].code, tbl[i].rdy);
            chk($sformatf("tbl%0d_live", i), liveBcd, tbl[i].live);
            chk($sformatf("tbl%0d_cnt", i), 9'(digitCount), 9'(tbl[i].cnt));
            chk($sformatf("tbl%0d_valid", i), 9'(outValid), 9'(tbl[i].v));
            chk($sformatf("tbl%0d_err", i), 9'(errPulse), 9'(tbl[i].e));
            chk($sformatf("tbl%0d_bcd", i), bcdOut, tbl[i].bcd);
        end

        for (int i = 0; i < 10; i++) step(1, 5, 0);
        chk("hold_cnt", 9'(digitCount), 9'd1);
        chk("hold_live", liveBcd, 9'h005);
        do_reset(1);
        for (int i = 0; i < 3; i++) step(1, 5, 0);
        chk("held_rst_cnt", 9'(digitCount), 9'd0);
        step(0, 5, 0);
        step(1, 5, 0);
        chk("repress_cnt", 9'(digitCount), 9'd1);
        chk("repress_live", liveBcd, 9'h005);
        step(0, 5, 0);

        step(1, 13, 0); step(0, 13, 0);
        step(1, 3, 0);
        chk("done_digit_bcd", bcdOut, 9'h005);
        chk("done_digit_live", liveBcd, 9'h005);
        chk("done_digit_valid", 9'(outValid), 9'd1);
        step(0, 3, 0);
        step(1, 12, 0);
        chk("done_clr_valid", 9'(outValid), 9'd0);
        chk("done_clr_cnt", 9'(digitCount), 9'd0);
        chk("done_clr_bcd", bcdOut, 9'h005);
        step(0, 12, 0);
        step(1, 6, 0); step(0, 6, 0); step(1, 13, 0); step(0, 13, 0);
        step(1, 12, 1);
        chk("clr_xfer_valid", 9'(outValid), 9'd0);
        chk("clr_xfer_live", liveBcd, 9'h000);
        chk("clr_xfer_bcd", bcdOut, 9'h006);
        step(0, 12, 0);
        step(1, 4, 0); step(0, 4, 0); step(1, 13, 0); step(0, 13, 0);
        do_reset(0);
        chk("rst_done_valid", 9'(outValid), 9'd0);
        chk("rst_done_bcd", bcdOut, 9'h000);

        rc = 4'd0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset(1'($urandom_range(0, 1)));
            else begin
                if (!keyPressed) rc = 4'($urandom_range(0, 15));
                step(1'($urandom_range(0, 1)), rc, $urandom_range(0, 3) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_entry.md
# bcd_entry

Keypad digit-entry stage for the calculator datapath. Accumulates up to two decimal digits and a sign from keypad key codes into a 9-bit sign + 2-digit BCD word, then presents it with a valid/ready handshake. The output feeds the BCD-to-binary converter. A live copy of the entry drives the seven-segment display.

## Interface
- No parameters; widths fixed: 4-bit key code, 9-bit BCD word {sign, tens[3:0], ones[3:0]}.
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- keyPressed  in  1  level from keypad scanner, already synchronised to clk; high while a key is held
- keyCode  in  4  code of held key, stable while keyPressed=1: 0–9 digit, 10 sign toggle, 11 backspace, 12 clear, 13 enter, 14–15 unused
- outReady  in  1  downstream accepts bcdOut this cycle
- bcdOut  out  9  entered word {sign, tens, ones}, held stable while outValid=1
- outValid  out  1  bcdOut is valid
- liveBcd  out  9  current entry {sign, tens, ones} for display
- digitCount  out  2  digits entered so far (0–2)
- errPulse  out  1  one-cycle pulse on a rejected key

## Operation
- Key event = keyPressed=1 sampled while prevKey=0 (prevKey is a 1-cycle registered copy). One event per press; held keys never repeat.
- States: EMPTY (count 0), PARTIAL (count 1), FULL (count 2), DONE (outValid=1).
- Digit d: EMPTY → ones=d, count=1, PARTIAL. PARTIAL → tens=ones, ones=d, count=2, FULL. FULL → entry unchanged, errPulse. Leading zero counts as a digit.
- Sign toggle (10): flips sign in EMPTY/PARTIAL/FULL. No error.
- Backspace (11): FULL → ones=tens, tens=0, PARTIAL. PARTIAL → ones=0, EMPTY. EMPTY → no change, no error. Sign unchanged.
- Clear (12): tens=ones=0, sign=0, EMPTY.
- Enter (13): in PARTIAL/FULL → bcdOut={sign',tens,ones}, outValid=1, DONE. sign' = 0 when tens=ones=0 (negative-zero suppression), else sign. In EMPTY → ignored, errPulse.
- Codes 14–15: ignored, no error, any state.
- DONE: all key events ignored except clear. Clear drops outValid and clears the entry to EMPTY. bcdOut holds its last value.
- Transfer: outValid=1 and outReady=1 at an edge → outValid=0, entry cleared (sign 0, digits 0), EMPTY.
- A simultaneous transfer and clear completes the transfer. Both produce the same resulting state.
- Key events coinciding with the transfer edge (other than clear) are discarded.
- liveBcd always reflects the current entry registers, including in DONE (frozen value).
- Digits entered are always 0–9, so BCD digits stay legal by construction.

## Timing
- Reset values: bcdOut=0, outValid=0, liveBcd=0, digitCount=0, errPulse=0, state EMPTY, prevKey=1.
- prevKey resets to 1, so a key held through reset is not accepted until it is released and pressed again.
- Key latency: the event edge updates the registers. liveBcd, digitCount, outValid and errPulse change at that edge and are visible in the following cycle.
- errPulse is high for exactly one cycle per rejected event.
- outValid rises one edge after the enter event. It stays high until the handshake edge and falls at that edge.
- bcdOut must not change while outValid=1.
- outReady is ignored when outValid=0.
- Reset mid-entry or while in DONE: everything returns to reset values at that edge. A pending outValid is dropped without transfer.

## Test plan
- Reset, then press 4, 2, enter with outReady=0 → liveBcd 0x042 after the second digit, bcdOut=0x042, outValid held high. Raise outReady → outValid falls next edge, liveBcd=0, digitCount=0.
- Press 7, sign, 3, enter, outReady=1 → bcdOut=0x173, one-cycle valid.
- Press 9, 8, 5 → third digit gives errPulse for one cycle, liveBcd stays 0x098. Backspace → 0x009, count 1. Backspace → 0x000, count 0. Backspace again → no errPulse.
- Sign, 0, enter → bcdOut=0x000 (sign suppressed). Enter on EMPTY → errPulse, outValid stays 0.
- Hold keyPressed with code 5 for 10 cycles → single digit accepted. Assert reset while a key is held, deassert reset, keep the key held → no digit accepted until release and re-press.
- In DONE, press digit 3 → ignored, bcdOut unchanged. Press clear with outReady=0 → outValid=0, entry EMPTY. Press clear and outReady in the same cycle → transfer completes, EMPTY.
